// File: rtl/i_type_exec_unit.sv
// i_type_exec_unit: handshaked RISC-V OP-IMM execute unit with serial shifter (IEXEC_BARREL_SHIFT_EN selects a single-cycle barrel shifter)
module i_type_exec_unit #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [2:0]      i_funct3,
  input  logic            i_arith,
  input  logic [XLEN-1:0] i_rv1,
  input  logic [XLEN-1:0] i_imm,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_rd_data,
  output logic            o_busy
);
  localparam int SW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t          r_state, w_next;
  logic [XLEN-1:0] r_rd_data, w_alu, w_res, w_shift_out;
  logic            w_accept, w_is_shift, w_start_shift, w_shift_done;
  logic [SW-1:0]   w_shamt;
  logic signed [XLEN-1:0] w_sra;
  assign w_accept    = i_in_valid && o_in_ready;
  assign w_is_shift  = i_funct3[1:0] == 2'b01;
  assign w_shamt     = i_imm[SW-1:0];
  assign o_in_ready  = r_state == IDLE || (r_state == DONE && i_out_ready);
  assign o_out_valid = r_state == DONE;
  assign o_rd_data   = r_rd_data;
  // Non-shift OP-IMM results; SLT compares are zero-extended to XLEN
  always_comb begin
    w_alu = i_funct3 == 3'b000 ? i_rv1 + i_imm :
            i_funct3 == 3'b010 ? XLEN'($signed(i_rv1) < $signed(i_imm)) :
            i_funct3 == 3'b011 ? XLEN'(i_rv1 < i_imm) :
            i_funct3 == 3'b100 ? i_rv1 ^ i_imm :
            i_funct3 == 3'b110 ? i_rv1 | i_imm : i_rv1 & i_imm;
  end
`ifdef IEXEC_BARREL_SHIFT_EN
  assign w_sra         = $signed(i_rv1) >>> w_shamt;
  assign w_shift_out   = i_funct3[2] ? (i_arith ? w_sra : i_rv1 >> w_shamt) : i_rv1 << w_shamt;
  assign w_start_shift = 1'b0;
  assign w_shift_done  = 1'b0;
  assign w_res         = w_is_shift ? w_shift_out : w_alu;
  assign o_busy        = 1'b0;
`else
  localparam logic [SW:0] STEP = (SW+1)'(SHIFT_STEP);
  logic [SW-1:0]   r_rem, w_rem_n;
  logic [XLEN-1:0] r_work;
  logic            r_left, r_sra;
  logic [SW:0]     w_k;
  assign w_k           = {1'b0, r_rem} > STEP ? STEP : {1'b0, r_rem};
  assign w_rem_n       = r_rem - w_k[SW-1:0];
  assign w_sra         = $signed(r_work) >>> w_k;
  assign w_shift_out   = r_left ? r_work << w_k : r_sra ? w_sra : r_work >> w_k;
  assign w_start_shift = w_accept && w_is_shift && w_shamt != '0;
  assign w_shift_done  = r_state == SHIFT && w_rem_n == '0;
  assign w_res         = w_is_shift ? i_rv1 : w_alu;
  assign o_busy        = r_state == SHIFT;
  // Serial shifter: load on accept, then advance up to SHIFT_STEP bits per cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_work <= '0;
      r_rem  <= '0;
      r_left <= 1'b0;
      r_sra  <= 1'b0;
    end else if (w_start_shift) begin
      r_work <= i_rv1;
      r_rem  <= w_shamt;
      r_left <= !i_funct3[2];
      r_sra  <= i_arith;
    end else if (r_state == SHIFT) begin
      r_work <= w_shift_out;
      r_rem  <= w_rem_n;
    end
  end
`endif
  // Next state: an accept in DONE restarts immediately so there is no bubble
  always_comb begin
    w_next = w_accept ? (w_start_shift ? SHIFT : DONE) :
             w_shift_done ? DONE :
             (r_state == DONE && i_out_ready) ? IDLE : r_state;
  end
  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end
  // Result register: written on immediate completion or when the shift finishes, held otherwise
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                        r_rd_data <= '0;
    else if (w_accept && !w_start_shift) r_rd_data <= w_res;
    else if (w_shift_done)               r_rd_data <= w_shift_out;
  end
endmodule
